// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the key/switch conditioning front end.
package key_cond_pkg;

    // Per-channel debounce state: stable low, verifying a rise, stable high, verifying a fall.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } chan_state_t;

    // 20 ms of stability at a 50 MHz clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam int unsigned DEFAULT_CNT_W           = 32'd20;

    // Map a synchronised raw level to "asserted" (1 = pressed / on).
    function automatic logic asserted_of(input logic raw_level, input logic active_low);
        return raw_level ^ active_low;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability FSM with saturating
// counter, and registered rise/fall pulses aligned with the level change.

// Elaboration-time parameter sanity check for a debounce channel.
module debounce_param_check #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd8,
    parameter int unsigned CNT_W           = 32'd4
) ();
    if (DEBOUNCE_CYCLES < 32'd1) begin : g_bad_cycles
        $error("debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end
    if (CNT_W < $clog2(DEBOUNCE_CYCLES + 32'd1)) begin : g_bad_width
        $error("debounce_channel: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
endmodule

module debounce_channel
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] TARGET  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    debounce_param_check #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_param_check ();

    logic [1:0]       sync_r;
    chan_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;
    logic             s;

    // Synchronised, polarity-corrected sample seen by the FSM this cycle.
    always_comb begin
        s = asserted_of(sync_r[1], ACTIVE_LOW);
    end

    // Synchroniser, stability FSM, saturating counter and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= {2{ACTIVE_LOW}};
            state_r <= IDLE_LOW;
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], raw};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                IDLE_LOW: begin
                    if (s) begin
                        state_r <= WAIT_HIGH;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_r <= IDLE_LOW;
                        cnt_r   <= '0;
                    end else if (cnt_r == TARGET) begin
                        state_r <= IDLE_HIGH;
                        cnt_r   <= '0;
                        level_r <= 1'b1;
                        rise_r  <= 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_r <= WAIT_LOW;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_r <= IDLE_HIGH;
                        cnt_r   <= '0;
                    end else if (cnt_r == TARGET) begin
                        state_r <= IDLE_LOW;
                        cnt_r   <= '0;
                        level_r <= 1'b0;
                        fall_r  <= 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE_LOW;
                    cnt_r   <= '0;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/key_conditioner.sv
// Board-input front end: debounces pushbuttons and slide switches and
// produces clean pressed levels plus one-cycle press/release pulses.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned N_KEYS          = 32'd2,
    parameter int unsigned N_SW            = 32'd1,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned KEY_ACTIVE_LOW  = 32'd1
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keyIn,
    input  logic [N_SW-1:0]   swIn,
    output logic [N_KEYS-1:0] keyLevel,
    output logic [N_KEYS-1:0] keyPress,
    output logic [N_KEYS-1:0] keyRelease,
    output logic [N_SW-1:0]   swLevel
);

    localparam bit KEY_INV = (KEY_ACTIVE_LOW != 32'd0);

    // Switches have no pulse outputs; their edge flops are left dangling.
    logic [N_SW-1:0] sw_rise_unused;
    logic [N_SW-1:0] sw_fall_unused;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (KEY_INV)
    ) u_key [N_KEYS-1:0] (
        .clk   (clockIn),
        .reset (reset),
        .raw   (keyIn),
        .level (keyLevel),
        .rise  (keyPress),
        .fall  (keyRelease)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACTIVE_LOW      (1'b0)
    ) u_sw [N_SW-1:0] (
        .clk   (clockIn),
        .reset (reset),
        .raw   (swIn),
        .level (swLevel),
        .rise  (sw_rise_unused),
        .fall  (sw_fall_unused)
    );

endmodule
